vote_tally: RTL and testbench
=============================

# vote_tally

Parametrised multi-candidate vote tally for the voting system. It holds one saturating counter per candidate and opens and closes the voting window under a small FSM. After close, it serially scans the tallies to report a winner and a tie flag. It generalises the single up-counter to N candidates, with window control, input validation, saturation and result computation.

## Interface

- N_CAND, default 4: number of candidates, 2..16.
- CNT_W, default 21: width of each per-candidate counter.
- SEL_W, default 2: width of vote_sel; must be ≥ clog2(N_CAND).

- clk  in  1  clock; all logic on posedge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  open a new election; clears all tallies.
- stop  in  1  close the voting window.
- vote_valid  in  1  vote present this cycle.
- vote_sel  in  SEL_W  candidate index of the vote.
- vote_ready  out  1  high only in OPEN; a vote is accepted when vote_valid && vote_ready.
- counts  out  N_CAND*CNT_W  registered tallies; candidate i occupies bits [i*CNT_W +: CNT_W].
- reject  out  1  one-cycle pulse, the cycle after a handshake with vote_sel ≥ N_CAND.
- sat  out  1  sticky flag; set when any vote hits a counter already at all-ones.
- busy  out  1  high in OPEN or SCAN.
- result_valid  out  1  high in DONE.
- winner  out  SEL_W  winning index; valid while result_valid.
- tie  out  1  another candidate equals the winner's count; valid while result_valid.

## Operation

- FSM states: IDLE, OPEN, SCAN, DONE.
- Reset: state IDLE; all counts 0; winner 0; tie, sat, reject, result_valid, busy, vote_ready all 0.
- IDLE:
  - start → OPEN; counts and sat cleared.
  - stop and votes are ignored.
- OPEN:
  - Accepted vote with vote_sel < N_CAND: counts[vote_sel] += 1.
  - At all-ones the counter holds and sat is set.
  - Accepted vote with vote_sel ≥ N_CAND: no count change; reject pulses.
  - start is ignored.
  - stop → SCAN. A vote accepted in the same cycle as stop is counted.
- SCAN: runs exactly N_CAND cycles, index i = 0..N_CAND-1, one candidate per cycle.
  - At i=0: best index = 0, best value = count0, tie = 0.
  - For i>0, count_i > best: best = i, tie = 0.
  - For i>0, count_i == best: tie = 1; best unchanged, so the lower index wins.
  - Count_i < best: no change.
  - After index N_CAND-1 → DONE.
  - Inputs are ignored.
- DONE:
  - winner, tie and counts are held.
  - start → OPEN with counts and sat cleared; result_valid drops.
  - stop and votes are ignored.
- Arithmetic:
  - Counters are unsigned CNT_W and never wrap.
  - Comparisons are unsigned over the full CNT_W.
- rst in any state, including mid-SCAN, returns to the reset values on the next edge.

## Timing

- Vote accepted at edge k: the counts update is visible after edge k; reject is high for the cycle after edge k.
- start sampled at edge k: the cleared counts, OPEN and vote_ready=1 are visible after edge k. A vote at edge k is not counted.
- stop sampled at edge k: SCAN runs for the N_CAND cycles after edge k. result_valid, winner and tie are valid after edge k+N_CAND.
- Close-to-result latency is N_CAND cycles.
- Throughput: one vote per cycle while OPEN.
- All outputs are registered; no combinational input-to-output path except vote_ready, which is decoded from state.

## Test plan

- Defaults. rst; start; votes for candidates 0,1,1,2,1,3; stop → after 4 cycles result_valid=1, winner=1, tie=0, counts={3:1, 2:1, 1:3, 0:1}.
- Tie. Votes 2,0,2,0; stop → winner=0, tie=1.
- Tie for a lower count does not flag. Votes 3,3,1,2; stop → winner=3, tie=0.
- Invalid vote and boundaries.
  - N_CAND=3, SEL_W=2, vote_sel=3 → reject pulses 1 cycle; counts unchanged.
  - A vote in the start cycle is not counted.
  - A vote in the stop cycle is counted.
- Saturation. CNT_W=3; 9 votes for candidate 0 → count0=7, sat=1; no wrap.
  - A new start clears counts and sat.
- Reset and ignored inputs.
  - rst asserted mid-SCAN → next cycle IDLE, all counts 0, result_valid=0.
  - Votes in IDLE or DONE do not change counts.

Source files
------------

// File: rtl/vote_tally.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vote_tally: N-candidate saturating vote counter with open/close window   |
// | control and a serial post-close winner/tie scan.                         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+

module vote_tally #(
  parameter int N_CAND = 4,
  parameter int CNT_W  = 21,
  parameter int SEL_W  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      stop,
  input  logic                      vote_valid,
  input  logic [SEL_W-1:0]          vote_sel,
  output logic                      vote_ready,
  output logic [N_CAND*CNT_W-1:0]   counts,
  output logic                      reject,
  output logic                      sat,
  output logic                      busy,
  output logic                      result_valid,
  output logic [SEL_W-1:0]          winner,
  output logic                      tie
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OPEN = 2'd1,
    ST_SCAN = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // One extra bit so N_CAND itself is representable for the range check.
  localparam logic [SEL_W:0]   N_EXT    = (SEL_W + 1)'(N_CAND);
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(N_CAND - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q [N_CAND];
  logic [CNT_W-1:0]   cnt_d [N_CAND];
  logic               sat_q, sat_d;
  logic               reject_q, reject_d;
  logic               busy_q, busy_d;
  logic               result_valid_q, result_valid_d;
  logic [SEL_W-1:0]   win_q, win_d;
  logic [CNT_W-1:0]   best_q, best_d;
  logic               tie_q, tie_d;
  logic [SEL_W-1:0]   idx_q, idx_d;

  logic               accept;
  logic               sel_ok;
  logic [CNT_W-1:0]   cur_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      for (int i = 0; i < N_CAND; i++) begin
        cnt_q[i] <= '0;
      end
      sat_q          <= 1'b0;
      reject_q       <= 1'b0;
      busy_q         <= 1'b0;
      result_valid_q <= 1'b0;
      win_q          <= '0;
      best_q         <= '0;
      tie_q          <= 1'b0;
      idx_q          <= '0;
    end else begin
      state_q        <= state_d;
      for (int i = 0; i < N_CAND; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      sat_q          <= sat_d;
      reject_q       <= reject_d;
      busy_q         <= busy_d;
      result_valid_q <= result_valid_d;
      win_q          <= win_d;
      best_q         <= best_d;
      tie_q          <= tie_d;
      idx_q          <= idx_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    for (int i = 0; i < N_CAND; i++) begin
      cnt_d[i] = cnt_q[i];
    end
    sat_d    = sat_q;
    reject_d = 1'b0;
    win_d    = win_q;
    best_d   = best_q;
    tie_d    = tie_q;
    idx_d    = idx_q;

    accept   = (state_q == ST_OPEN) && vote_valid;
    sel_ok   = ({1'b0, vote_sel} < N_EXT);
    cur_cnt  = cnt_q[idx_q];

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_OPEN;
          for (int i = 0; i < N_CAND; i++) begin
            cnt_d[i] = '0;
          end
          sat_d = 1'b0;
        end
      end

      ST_OPEN: begin
        if (accept) begin
          if (sel_ok) begin
            for (int i = 0; i < N_CAND; i++) begin
              if (vote_sel == SEL_W'(i)) begin
                if (cnt_q[i] == CNT_MAX) begin
                  sat_d = 1'b1;
                end else begin
                  cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
              end
            end
          end else begin
            reject_d = 1'b1;
          end
        end
        if (stop) begin
          state_d = ST_SCAN;
          idx_d   = '0;
        end
      end

      ST_SCAN: begin
        // Strict greater-than keeps the lower index on equal counts.
        if (idx_q == '0) begin
          win_d  = '0;
          best_d = cur_cnt;
          tie_d  = 1'b0;
        end else if (cur_cnt > best_q) begin
          win_d  = idx_q;
          best_d = cur_cnt;
          tie_d  = 1'b0;
        end else if (cur_cnt == best_q) begin
          tie_d  = 1'b1;
        end
        if (idx_q == LAST_IDX) begin
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + SEL_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d         = (state_d == ST_OPEN) || (state_d == ST_SCAN);
    result_valid_d = (state_d == ST_DONE);
  end

  assign vote_ready   = (state_q == ST_OPEN);
  assign reject       = reject_q;
  assign sat          = sat_q;
  assign busy         = busy_q;
  assign result_valid = result_valid_q;
  assign winner       = win_q;
  assign tie          = tie_q;

  generate
    for (genvar g = 0; g < N_CAND; g++) begin : g_pack
      assign counts[g*CNT_W +: CNT_W] = cnt_q[g];
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_vote_tally.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_vote_tally: directed bench for vote_tally, default and small configs. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+

module tb_vote_tally;

  logic clk;
  logic rst;

  // Instance A: defaults (4 candidates, 21-bit counters)
  logic        a_start, a_stop, a_valid;
  logic [1:0]  a_sel;
  logic        a_ready, a_reject, a_sat, a_busy, a_rv, a_tie;
  logic [83:0] a_counts;
  logic [1:0]  a_winner;

  // Instance B: 3 candidates, 3-bit counters
  logic        b_start, b_stop, b_valid;
  logic [1:0]  b_sel;
  logic        b_ready, b_reject, b_sat, b_busy, b_rv, b_tie;
  logic [8:0]  b_counts;
  logic [1:0]  b_winner;

  int checks;
  int failures;

  vote_tally u_dut_a (
    .clk(clk), .rst(rst), .start(a_start), .stop(a_stop),
    .vote_valid(a_valid), .vote_sel(a_sel), .vote_ready(a_ready),
    .counts(a_counts), .reject(a_reject), .sat(a_sat), .busy(a_busy),
    .result_valid(a_rv), .winner(a_winner), .tie(a_tie)
  );

  vote_tally #(.N_CAND(3), .CNT_W(3), .SEL_W(2)) u_dut_b (
    .clk(clk), .rst(rst), .start(b_start), .stop(b_stop),
    .vote_valid(b_valid), .vote_sel(b_sel), .vote_ready(b_ready),
    .counts(b_counts), .reject(b_reject), .sat(b_sat), .busy(b_busy),
    .result_valid(b_rv), .winner(b_winner), .tie(b_tie)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach summary");
    $fatal(1, "timeout");
  end

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_vote(input logic [1:0] s);
    a_valid = 1'b1; a_sel = s;
    tick();
    a_valid = 1'b0;
  endtask

  task automatic a_pulse_start();
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
  endtask

  task automatic b_vote(input logic [1:0] s);
    b_valid = 1'b1; b_sel = s;
    tick();
    b_valid = 1'b0;
  endtask

  task automatic b_pulse_start();
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
  endtask

  task automatic a_stop_and_scan();
    a_stop = 1'b1;
    tick();
    a_stop = 1'b0;
    repeat (4) tick();
  endtask

  task automatic b_stop_and_scan();
    b_stop = 1'b1;
    tick();
    b_stop = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    checks++; if (a_counts !== 84'd0) begin failures++; $display("FAIL reset_counts: got %h expected 0", a_counts); end
    checks++; if ({a_ready, a_reject, a_sat, a_busy, a_rv, a_tie} !== 6'b0) begin failures++; $display("FAIL reset_flags: got %b expected 000000", {a_ready, a_reject, a_sat, a_busy, a_rv, a_tie}); end
    checks++; if (a_winner !== 2'd0) begin failures++; $display("FAIL reset_winner: got %0d expected 0", a_winner); end
    checks++; if (b_counts !== 9'd0 || b_busy !== 1'b0) begin failures++; $display("FAIL reset_b: counts %h busy %b expected 0 0", b_counts, b_busy); end
  endtask

  task automatic test_default();
    logic [83:0] exp;
    exp = {21'd1, 21'd1, 21'd3, 21'd1};
    a_pulse_start();
    checks++; if (a_ready !== 1'b1 || a_busy !== 1'b1) begin failures++; $display("FAIL open_state: ready %b busy %b expected 1 1", a_ready, a_busy); end
    a_vote(0); a_vote(1); a_vote(1); a_vote(2); a_vote(1); a_vote(3);
    checks++; if (a_counts !== exp) begin failures++; $display("FAIL default_counts_open: got %h expected %h", a_counts, exp); end
    a_stop = 1'b1;
    tick();
    a_stop = 1'b0;
    checks++; if (a_busy !== 1'b1 || a_rv !== 1'b0 || a_ready !== 1'b0) begin failures++; $display("FAIL scan_entry: busy %b rv %b ready %b expected 1 0 0", a_busy, a_rv, a_ready); end
    repeat (3) tick();
    checks++; if (a_rv !== 1'b0) begin failures++; $display("FAIL latency_early: rv %b expected 0 at stop+3", a_rv); end
    tick();
    checks++; if (a_rv !== 1'b1 || a_busy !== 1'b0) begin failures++; $display("FAIL latency_done: rv %b busy %b expected 1 0 at stop+4", a_rv, a_busy); end
    checks++; if (a_winner !== 2'd1 || a_tie !== 1'b0) begin failures++; $display("FAIL default_result: winner %0d tie %b expected 1 0", a_winner, a_tie); end
    checks++; if (a_counts !== exp) begin failures++; $display("FAIL default_counts_done: got %h expected %h", a_counts, exp); end
  endtask

  task automatic test_ignored_in_done();
    logic [83:0] exp;
    exp = {21'd1, 21'd1, 21'd3, 21'd1};
    a_vote(0); a_vote(2);
    a_stop = 1'b1; tick(); a_stop = 1'b0;
    checks++; if (a_counts !== exp || a_rv !== 1'b1) begin failures++; $display("FAIL done_ignore: counts %h rv %b expected %h 1", a_counts, a_rv, exp); end
    checks++; if (a_winner !== 2'd1 || a_tie !== 1'b0) begin failures++; $display("FAIL done_hold: winner %0d tie %b expected 1 0", a_winner, a_tie); end
  endtask

  task automatic test_tie();
    a_pulse_start();
    checks++; if (a_counts !== 84'd0 || a_rv !== 1'b0) begin failures++; $display("FAIL restart_clear: counts %h rv %b expected 0 0", a_counts, a_rv); end
    a_vote(2); a_vote(0); a_vote(2); a_vote(0);
    a_stop_and_scan();
    checks++; if (a_rv !== 1'b1 || a_winner !== 2'd0 || a_tie !== 1'b1) begin failures++; $display("FAIL tie_result: rv %b winner %0d tie %b expected 1 0 1", a_rv, a_winner, a_tie); end
  endtask

  task automatic test_low_tie();
    a_pulse_start();
    a_vote(3); a_vote(3); a_vote(1); a_vote(2);
    a_stop_and_scan();
    checks++; if (a_rv !== 1'b1 || a_winner !== 2'd3 || a_tie !== 1'b0) begin failures++; $display("FAIL low_tie_result: rv %b winner %0d tie %b expected 1 3 0", a_rv, a_winner, a_tie); end
  endtask

  task automatic test_start_stop_boundary();
    logic [83:0] exp;
    exp = {21'd0, 21'd0, 21'd1, 21'd0};
    a_valid = 1'b1; a_sel = 2'd2; a_start = 1'b1;
    tick();
    a_valid = 1'b0; a_start = 1'b0;
    checks++; if (a_counts !== 84'd0) begin failures++; $display("FAIL start_cycle_vote: counts %h expected 0", a_counts); end
    a_valid = 1'b1; a_sel = 2'd1; a_stop = 1'b1;
    tick();
    a_valid = 1'b0; a_stop = 1'b0;
    checks++; if (a_counts !== exp) begin failures++; $display("FAIL stop_cycle_vote: counts %h expected %h", a_counts, exp); end
    repeat (4) tick();
    checks++; if (a_rv !== 1'b1 || a_winner !== 2'd1 || a_tie !== 1'b0) begin failures++; $display("FAIL stop_cycle_result: rv %b winner %0d tie %b expected 1 1 0", a_rv, a_winner, a_tie); end
  endtask

  task automatic test_reset_mid_scan();
    a_pulse_start();
    a_vote(0); a_vote(3);
    a_stop = 1'b1; tick(); a_stop = 1'b0;
    tick();
    checks++; if (a_busy !== 1'b1) begin failures++; $display("FAIL mid_scan_busy: busy %b expected 1", a_busy); end
    rst = 1'b1; tick(); rst = 1'b0;
    checks++; if (a_counts !== 84'd0 || a_rv !== 1'b0 || a_busy !== 1'b0 || a_ready !== 1'b0) begin failures++; $display("FAIL mid_scan_reset: counts %h rv %b busy %b ready %b expected 0 0 0 0", a_counts, a_rv, a_busy, a_ready); end
    a_vote(2); a_vote(0);
    a_stop = 1'b1; tick(); a_stop = 1'b0;
    checks++; if (a_counts !== 84'd0 || a_busy !== 1'b0) begin failures++; $display("FAIL idle_ignore: counts %h busy %b expected 0 0", a_counts, a_busy); end
  endtask

  task automatic test_reject();
    b_pulse_start();
    b_vote(3);
    checks++; if (b_reject !== 1'b1 || b_counts !== 9'd0) begin failures++; $display("FAIL reject_pulse: reject %b counts %h expected 1 0", b_reject, b_counts); end
    tick();
    checks++; if (b_reject !== 1'b0) begin failures++; $display("FAIL reject_width: reject %b expected 0", b_reject); end
    b_vote(1);
    checks++; if (b_reject !== 1'b0 || b_counts !== 9'b000_001_000) begin failures++; $display("FAIL valid_after_reject: reject %b counts %h expected 0 %h", b_reject, b_counts, 9'b000_001_000); end
    b_stop_and_scan();
    checks++; if (b_rv !== 1'b1 || b_winner !== 2'd1 || b_tie !== 1'b0) begin failures++; $display("FAIL b_result: rv %b winner %0d tie %b expected 1 1 0", b_rv, b_winner, b_tie); end
  endtask

  task automatic test_saturation();
    b_pulse_start();
    repeat (7) b_vote(0);
    checks++; if (b_counts !== 9'd7 || b_sat !== 1'b0) begin failures++; $display("FAIL sat_edge: counts %h sat %b expected 007 0", b_counts, b_sat); end
    b_vote(0);
    checks++; if (b_counts !== 9'd7 || b_sat !== 1'b1) begin failures++; $display("FAIL sat_hit: counts %h sat %b expected 007 1", b_counts, b_sat); end
    b_vote(0);
    checks++; if (b_counts !== 9'd7 || b_sat !== 1'b1) begin failures++; $display("FAIL sat_hold: counts %h sat %b expected 007 1", b_counts, b_sat); end
    b_stop_and_scan();
    checks++; if (b_winner !== 2'd0 || b_tie !== 1'b0 || b_sat !== 1'b1) begin failures++; $display("FAIL sat_result: winner %0d tie %b sat %b expected 0 0 1", b_winner, b_tie, b_sat); end
    b_pulse_start();
    checks++; if (b_counts !== 9'd0 || b_sat !== 1'b0) begin failures++; $display("FAIL sat_clear: counts %h sat %b expected 0 0", b_counts, b_sat); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    a_start = 1'b0; a_stop = 1'b0; a_valid = 1'b0; a_sel = 2'd0;
    b_start = 1'b0; b_stop = 1'b0; b_valid = 1'b0; b_sel = 2'd0;
    tick();
    test_reset();
    test_default();
    test_ignored_in_done();
    test_tie();
    test_low_tie();
    test_start_stop_boundary();
    test_reset_mid_scan();
    test_reject();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
